// File: rtl/spi_pkg.sv
// SPI master shared definitions: register map,
// control-bit positions and FSM state encoding.
package spi_pkg;

  localparam logic [1:0] ADR_DATA = 2'd0;
  localparam logic [1:0] ADR_CTRL = 2'd1;
  localparam logic [1:0] ADR_DIV  = 2'd2;

  localparam int CB_IEN  = 15;
  localparam int CB_LEN  = 8;
  localparam int CB_CPOL = 7;
  localparam int CB_CPHA = 6;
  localparam int CB_MCS  = 4;
  localparam int CB_DONE = 3;
  localparam int CB_OVR  = 2;
  localparam int CB_BUSY = 0;

  localparam logic [3:0] LEN_RST = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/spi_if.sv
// Register bus between a host and the SPI master.
// The peripheral side uses the slave modport.
interface spi_if;
  logic [1:0]  i_dbus_adr;
  logic        i_dbus_cyc;
  logic        i_dbus_we;
  logic [15:0] i_dbus_dat;
  logic [15:0] o_dbus_rdt;
  logic        o_dbus_ack;

  modport master (
    output i_dbus_adr, i_dbus_cyc,
    output i_dbus_we, i_dbus_dat,
    input  o_dbus_rdt, o_dbus_ack
  );

  modport slave (
    input  i_dbus_adr, i_dbus_cyc,
    input  i_dbus_we, i_dbus_dat,
    output o_dbus_rdt, o_dbus_ack
  );
endinterface

// File: rtl/spi_clkgen.sv
// SCLK half-period timer: tick on the last clk of
// every (div+1)-cycle half-period while enabled.
module spi_clkgen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  assign tick = en && (cnt_q == div);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (!en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Register-mapped SPI master, modes 0-3, 1..16 bit
// frames, MSB first, optional manual chip select.
module spi_master #(
  parameter int DIV_W = 8
) (
  input  logic clk,
  input  logic rstn,
  spi_if.slave bus,
  output logic o_int,
  output logic o_SCLK,
  output logic o_MOSI,
  input  logic i_MISO,
  output logic o_CSn
);
  import spi_pkg::*;

  state_t state_q, state_d;

  logic             ack_q;
  logic [15:0]      rdt_q, rd_mux, ctrl_rd;
  logic             ien_q, cpol_q, cpha_q, mcs_q;
  logic [3:0]       len_q;
  logic             done_q, ovr_q;
  logic [DIV_W-1:0] div_q;
  logic [15:0]      rx_q, rx_sh, tx_q;
  logic [3:0]       len_l;
  logic             cpol_l, cpha_l;
  logic [DIV_W-1:0] div_l;
  logic             sclk_q;
  logic [4:0]       edge_q;

  logic acc, wr, rd, wr_data, start, busy;
  logic clk_en, tick, last_edge, samp, shft;

  assign acc     = bus.i_dbus_cyc & ack_q;
  assign wr      = acc & bus.i_dbus_we;
  assign rd      = acc & ~bus.i_dbus_we;
  assign wr_data = wr && (bus.i_dbus_adr == ADR_DATA);
  assign busy    = (state_q != ST_IDLE);
  assign start   = wr_data && !busy;

  assign bus.o_dbus_ack = ack_q;
  assign bus.o_dbus_rdt = rdt_q;

  spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk  (clk),
    .rstn (rstn),
    .en   (clk_en),
    .div  (div_l),
    .tick (tick)
  );

  // Even edge counts are leading edges, odd are trailing
  assign last_edge = (edge_q == {len_l, 1'b1});
  assign samp = (edge_q[0] == cpha_l);
  assign shft = cpha_l ? (~edge_q[0] & (edge_q != 5'd0))
                       : edge_q[0];

  always_comb begin
    state_d = state_q;
    clk_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        clk_en = 1'b1;
        if (tick) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        clk_en = 1'b1;
        if (tick && last_edge) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        clk_en = 1'b1;
        if (tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CB_IEN]     = ien_q;
    ctrl_rd[CB_LEN+:4]  = len_q;
    ctrl_rd[CB_CPOL]    = cpol_q;
    ctrl_rd[CB_CPHA]    = cpha_q;
    ctrl_rd[CB_MCS]     = mcs_q;
    ctrl_rd[CB_DONE]    = done_q;
    ctrl_rd[CB_OVR]     = ovr_q;
    ctrl_rd[CB_BUSY]    = busy;
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      bus.i_dbus_adr == ADR_DATA: rd_mux = rx_q;
      bus.i_dbus_adr == ADR_CTRL: rd_mux = ctrl_rd;
      bus.i_dbus_adr == ADR_DIV:  rd_mux = 16'(div_q);
      default:                    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_q  <= 1'b0;
      rdt_q  <= '0;
      ien_q  <= 1'b0;
      len_q  <= LEN_RST;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      mcs_q  <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
      div_q  <= '0;
      rx_q   <= '0;
      rx_sh  <= '0;
      tx_q   <= '0;
      len_l  <= LEN_RST;
      cpol_l <= 1'b0;
      cpha_l <= 1'b0;
      div_l  <= '0;
      sclk_q <= 1'b0;
      edge_q <= '0;
    end else begin
      ack_q <= bus.i_dbus_cyc & ~ack_q;
      if (bus.i_dbus_cyc & ~ack_q) rdt_q <= rd_mux;

      if (wr && (bus.i_dbus_adr == ADR_CTRL)) begin
        ien_q  <= bus.i_dbus_dat[CB_IEN];
        len_q  <= bus.i_dbus_dat[CB_LEN+:4];
        cpol_q <= bus.i_dbus_dat[CB_CPOL];
        cpha_q <= bus.i_dbus_dat[CB_CPHA];
        mcs_q  <= bus.i_dbus_dat[CB_MCS];
        if (bus.i_dbus_dat[CB_OVR]) ovr_q <= 1'b0;
      end
      if (wr && (bus.i_dbus_adr == ADR_DIV))
        div_q <= bus.i_dbus_dat[DIV_W-1:0];
      if (wr_data && busy) ovr_q <= 1'b1;

      // Transfer runs on a snapshot of the config
      if (start) begin
        tx_q   <= bus.i_dbus_dat;
        rx_sh  <= '0;
        len_l  <= len_q;
        cpol_l <= cpol_q;
        cpha_l <= cpha_q;
        div_l  <= div_q;
        sclk_q <= cpol_q;
        edge_q <= '0;
      end

      if ((state_q == ST_SHIFT) && tick) begin
        sclk_q <= ~sclk_q;
        edge_q <= edge_q + 5'd1;
        if (samp) rx_sh <= {rx_sh[14:0], i_MISO};
        if (shft) tx_q <= {tx_q[14:0], 1'b0};
      end

      if (rd && (bus.i_dbus_adr == ADR_DATA)) done_q <= 1'b0;
      if ((state_q == ST_HOLD) && tick) begin
        done_q <= 1'b1;
        rx_q   <= rx_sh;
      end
    end
  end

  assign o_int  = done_q & ien_q;
  assign o_CSn  = ~(busy | mcs_q);
  assign o_SCLK = (state_q == ST_IDLE) ? cpol_q : sclk_q;
  assign o_MOSI = busy & tx_q[len_l];

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter DIV_W, default 8, meaning the width of the SCLK divider register.
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-003 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_dbus_adr  input  2  register select: 0 data, 1 control/status, 2 divider.
REQ-005 SHALL have ports i_dbus_cyc (input, 1, bus cycle), i_dbus_we (input, 1, write), i_dbus_dat (input, 16, write data).
REQ-006 SHALL have ports o_dbus_rdt (output, 16, read data) and o_dbus_ack (output, 1, one-cycle acknowledge).
REQ-007 SHALL have port o_int  output  1  level interrupt.
REQ-008 SHALL have ports o_SCLK (output, 1), o_MOSI (output, 1), i_MISO (input, 1), o_CSn (output, 1, active low).

Function
REQ-009 o_dbus_ack SHALL register i_dbus_cyc & !o_dbus_ack, giving one ack per two-cycle access; writes take effect on the ack cycle.
REQ-010 Control register bits SHALL be: [15] done-int enable (R/W), [11:8] LEN = bits-1 (R/W), [7:6] CPOL,CPHA (R/W), [4] manual CS (R/W), [3] done (R), [2] overrun (R, write-1-clear), [0] busy (R).
REQ-011 Divider register (adr 2) SHALL set the SCLK half-period to DIV+1 clk cycles.
REQ-012 A data write while idle SHALL load the TX shift register and start a transfer; a data write while busy SHALL be ignored and set overrun.
REQ-013 The FSM SHALL be IDLE -> SETUP -> SHIFT -> HOLD -> IDLE; each of SETUP and HOLD lasts one half-period; SHIFT lasts 2*(LEN+1) half-periods.
REQ-014 o_CSn SHALL be 0 in SETUP, SHIFT and HOLD, or whenever manual CS = 1; otherwise it SHALL be 1.
REQ-015 o_SCLK SHALL equal CPOL in IDLE, SETUP and HOLD, and SHALL toggle on every half-period boundary in SHIFT.
REQ-016 Bits SHALL be transmitted MSB first, starting at bit LEN; only bits [LEN:0] are used.
REQ-017 CPHA=0: o_MOSI SHALL be valid from SETUP entry; sample i_MISO on leading edges; shift on trailing edges.
REQ-018 CPHA=1: shift on leading edges; sample i_MISO on trailing edges.
REQ-019 On HOLD->IDLE, received bits SHALL be right-aligned in the RX register, upper bits zero, and done SHALL be set.
REQ-020 A data read (ack cycle) SHALL return the RX register and clear done; done SHALL win if set and cleared in the same cycle.
REQ-021 o_int SHALL equal done & ctrl[15].
REQ-022 Control and divider writes during busy SHALL update stored values, but the active transfer SHALL use values latched at start.
REQ-023 busy SHALL be 1 from the cycle after the starting ack until IDLE is re-entered.

Reset
REQ-024 On rstn=0, regardless of state: FSM=IDLE, o_SCLK=0, o_CSn=1, o_MOSI=0, o_int=0, o_dbus_ack=0, o_dbus_rdt=0, ctrl=16'h0700 (8-bit, mode 0, int off), divider=0, RX=0, flags=0.
REQ-025 Reset asserted mid-transfer SHALL abort with no done flag set.

Structure
REQ-026 Register addresses, control-bit indices and FSM state encodings SHALL live in a shared package spi_pkg.
REQ-027 The SCLK half-period timer SHALL be a sub-module spi_clkgen (counter, enable, half-period tick output); everything else stays in spi_master.

Verification
REQ-028 Mode 0, DIV=1, LEN=7: write 16'h00A5, slave returns 8'h3C -> MOSI 1010_0101 MSB first, SCLK period 4 clk, read data 16'h003C, done=1 then 0 after read.
REQ-029 Mode 3, LEN=15, tx 16'hBEEF, MISO loopback -> o_SCLK idles 1, RX=16'hBEEF, CSn low for exactly (2*16+2)*(DIV+1) clk.
REQ-030 Write data while busy -> transfer unaffected, overrun=1; write ctrl[2]=1 -> overrun=0.
REQ-031 ctrl[15]=1, transfer completes -> o_int=1 until data read, then 0.
REQ-032 Manual CS=1, two back-to-back transfers -> o_CSn stays 0 between them.
REQ-033 rstn pulsed low during SHIFT -> outputs at reset values in the same cycle, done=0, new transfer after release works.
